// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: holds the 12-bit PC, reads the one-cycle-latency
// instruction memory, issues each word over a valid/ready handshake, applies
// PC-relative jumps from the control unit, stops on HALT and counts retirements.
module instruction_fetch_unit #(
    parameter logic [11:0] RESET_PC    = 12'h000,
    parameter logic [3:0]  HALT_OPCODE = 4'b1111
) (
    input  logic        clk,
    input  logic        reset,
    output logic [11:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    output logic [15:0] inst,
    output logic        inst_valid,
    input  logic        issue_ready,
    input  logic        jump_taken,
    input  logic [11:0] jump_offset,
    input  logic        resume,
    output logic [11:0] pc,
    output logic        halted,
    output logic [15:0] retire_count
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [11:0] pc_next;
    logic        transfer;
    logic        is_halt;
    logic        do_resume;

    // The memory is always addressed by the PC; only imem_rd qualifies it.
    assign imem_addr = pc;
    assign transfer  = (state == S_ISSUE) && issue_ready;
    assign is_halt   = (inst[15:12] == HALT_OPCODE);
    assign do_resume = (state == S_HALT) && resume;

    // State register; reset restarts fetching at RESET_PC.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state, next PC and memory read strobe.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_next = state;
        pc_next    = pc;
        imem_rd    = 1'b0;
        unique case (state)
            S_FETCH: begin
                // Keep the strobe low while reset is held so the memory sees
                // no read until the stage actually starts.
                imem_rd    = !reset;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    if (is_halt) begin
                        state_next = S_HALT;
                    end else begin
                        state_next = S_FETCH;
                        pc_next    = jump_taken ? (pc + jump_offset) : (pc + 12'd1);
                    end
                end
            end
            S_HALT: begin
                if (resume) begin
                    state_next = S_FETCH;
                    pc_next    = pc + 12'd1;
                end
            end
        endcase
    end

    // Datapath: PC, instruction register, valid flag, halt flag, retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            inst         <= 16'h0000;
            inst_valid   <= 1'b0;
            halted       <= 1'b0;
            retire_count <= 16'h0000;
        end else begin
            pc <= pc_next;
            if (state == S_WAIT) begin
                inst       <= imem_data;
                inst_valid <= 1'b1;
            end
            if (transfer) begin
                inst_valid   <= 1'b0;
                retire_count <= retire_count + 16'd1;
                if (is_halt) begin
                    halted <= 1'b1;
                end
            end
            if (do_resume) begin
                halted <= 1'b0;
            end
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Program-counter and instruction-fetch stage that feeds the 16-bit instruction word to the control unit. It holds the 12-bit PC and reads the synchronous instruction memory, which has one-cycle read latency. It presents each instruction with a valid/ready handshake. It applies the PC-relative jump decision returned by the control unit, stops on a HALT opcode, and counts retired instructions.

## Interface
- RESET_PC, 12'h000, PC value loaded on reset
- HALT_OPCODE, 4'b1111, opcode (inst[15:12]) that halts fetch

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_addr  out  12  instruction memory address; always equals pc
- imem_rd  out  1  memory read strobe; high only in FETCH
- imem_data  in  16  memory read data; valid the cycle after imem_rd
- inst  out  16  instruction register, to control unit
- inst_valid  out  1  inst holds an unconsumed instruction
- issue_ready  in  1  downstream accepts inst this cycle
- jump_taken  in  1  control unit jump decision for the current inst
- jump_offset  in  12  PC-relative offset, two's complement, from control unit
- resume  in  1  single-cycle pulse that leaves HALT
- pc  out  12  address of the instruction in inst / being fetched
- halted  out  1  fetch stopped on HALT_OPCODE
- retire_count  out  16  number of instructions consumed

## Operation
- Reset values:
  - pc = RESET_PC, state = FETCH
  - inst = 16'h0000, inst_valid = 0, imem_rd = 0
  - halted = 0, retire_count = 0
- FETCH: imem_rd = 1, imem_addr = pc; next state is WAIT.
- WAIT: at the clock edge, inst <= imem_data and inst_valid <= 1; next state is ISSUE.
- ISSUE: inst_valid = 1; without issue_ready, hold all state (the stall can last any length).
- Issue, normal: on issue_ready, inst_valid <= 0 and retire_count <= retire_count + 1.
- Issue, opcode != HALT_OPCODE:
  - pc <= jump_taken ? pc + jump_offset : pc + 1
  - next state is FETCH
- Issue, opcode == HALT_OPCODE:
  - pc holds, halted <= 1, next state is HALT
  - jump_taken is ignored
  - the HALT instruction counts as retired
- HALT: imem_rd = 0, inst_valid = 0.
- Resume: on resume, pc <= pc + 1, halted <= 0, next state is FETCH.
- resume outside HALT is ignored.
- Arithmetic: all PC arithmetic is modulo 2^12 (12'hFFF + 1 = 12'h000; 12'h002 + 12'hFFE = 12'h000).
- retire_count wraps from 16'hFFFF to 16'h0000.
- jump_offset = 0 with jump_taken = 1 gives a self-loop: same pc, refetched.
- jump_taken and jump_offset are sampled only in ISSUE with issue_ready = 1; they are don't-care otherwise.
- reset overrides every other input in the same cycle, including mid-stall, in WAIT, and in HALT.
  - Any pending instruction is discarded; it is not counted.

## Timing
- Latency: 3 cycles per instruction with no stall (FETCH, WAIT, ISSUE).
- Throughput: 1 instruction / 3 cycles max.
- First inst_valid goes high 2 cycles after the reset-release edge.
- imem_data is sampled only at the WAIT→ISSUE edge.
- The memory may change imem_data at any other time.
- Handshake: transfer when inst_valid && issue_ready at a rising edge.
  - inst and pc are stable while inst_valid = 1 and issue_ready = 0.
- Control-unit contract: jump_taken and jump_offset must be valid combinationally in the ISSUE cycle.
  - They are derived from inst and the flags.
- pc update, halted set, and the retire_count increment all occur at the same edge as the transfer.
- From HALT, imem_rd goes high 1 cycle after the resume edge.

## Test plan
- Sequential run:
  - Stimulus: reset with RESET_PC = 0; memory[0..2] = 16'h2123, 16'h7105, 16'hF000; issue_ready = 1.
  - Required: inst_valid pulses at cycles 2, 5, 8; pc = 0, 1, 2; halted = 1 after cycle 8; retire_count = 3; imem_rd stays low afterwards.
- Taken jump:
  - Stimulus: inst at pc = 12'h010 with jump_taken = 1, jump_offset = 12'hFFC.
  - Required: next imem_addr = 12'h00C.
  - Stimulus: same inst with jump_taken = 0.
  - Required: next imem_addr = 12'h011.
- Stall:
  - Stimulus: issue_ready = 0 for 5 cycles in ISSUE while jump_taken toggles.
  - Required: inst, pc, inst_valid and retire_count are unchanged.
  - Stimulus: issue_ready then goes high with jump_taken = 0.
  - Required: pc advances by 1, retire_count advances by 1.
- Wrap-around:
  - Stimulus: pc = 12'hFFF, non-jump instruction issued.
  - Required: next imem_addr = 12'h000.
  - Stimulus: offset 12'h001 from 12'hFFF.
  - Required: target = 12'h000.
- Halt/resume:
  - Stimulus: HALT at pc = 12'h020, then resume pulse.
  - Required: halted drops; imem_addr = 12'h021 with imem_rd = 1 on the next cycle.
  - Stimulus: resume pulse while in FETCH.
  - Required: no effect.
- Reset mid-operation:
  - Stimulus: assert reset in ISSUE with inst_valid = 1 and issue_ready = 1.
  - Required: next cycle pc = RESET_PC, inst_valid = 0, inst = 16'h0000, retire_count = 0.
  - Required: no increment or jump is applied.
